// File: rtl/rr_issue_select_if.sv
// rtl/rr_issue_select_if.sv - request/grant bundle between a reservation-station bank and its issue selector
interface rr_issue_select_if #(
  parameter int NUM_REQ = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic               outReady;
  logic               grantValid;
  logic [IDX_W-1:0]   grantIdx;
  logic [NUM_REQ-1:0] grantOneHot;
  logic               issueFire;

  modport master (
    input  req,
    input  outReady,
    output grantValid,
    output grantIdx,
    output grantOneHot,
    output issueFire
  );

  modport slave (
    output req,
    output outReady,
    input  grantValid,
    input  grantIdx,
    input  grantOneHot,
    input  issueFire
  );
endinterface

// File: rtl/rr_issue_select.sv
// rtl/rr_issue_select.sv - registered round-robin issue arbiter for an N-entry reservation-station bank
// grantIdx feeds the bank's N:1 operand mux select; grantOneHot lets the bank free the issued entry.
module rr_issue_select #(
  parameter int NUM_REQ    = 8,
  parameter int GATE_DELAY = 50
) (
  input  logic               clk,
  input  logic               reset,
  rr_issue_select_if.master  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || (NUM_REQ & (NUM_REQ - 1)) != 0) begin : g_bad_num_req
    $error("rr_issue_select: NUM_REQ must be a power of two and >= 2");
  end
  if (GATE_DELAY < 0) begin : g_bad_gate_delay
    $error("rr_issue_select: GATE_DELAY must be non-negative");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] oh_q, oh_d;

  logic               fire;
  logic               slot_free;
  logic [NUM_REQ-1:0] excl;
  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   base;
  logic [IDX_W-1:0]   probe;
  logic [IDX_W-1:0]   win_idx;
  logic               found;

  assign fire            = (state_q == HELD) && bus.outReady;
  assign slot_free       = (state_q == EMPTY) || fire;
  assign bus.issueFire   = fire;
  assign bus.grantValid  = (state_q == HELD);
  assign bus.grantIdx    = idx_q;
  assign bus.grantOneHot = oh_q;

  // The entry leaving this cycle still has req high (the bank drops it a
  // cycle later), so it is masked out and the scan starts just past it.
  always_comb begin
    excl    = fire ? oh_q : '0;
    cand    = bus.req & ~excl;
    base    = fire ? idx_q + 1'b1 : ptr_q;
    probe   = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      probe = base + IDX_W'(i);
      if (!found && cand[probe]) begin
        found   = 1'b1;
        win_idx = probe;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    ptr_d   = ptr_q;
    if (fire) begin
      ptr_d = idx_q + 1'b1;
    end
    // While HELD without fire nothing moves, so the mux select stays bit-stable.
    case (state_q)
      EMPTY, HELD: begin
        if (slot_free) begin
          if (found) begin
            state_d = HELD;
            idx_d   = win_idx;
            oh_d    = NUM_REQ'(1) << win_idx;
          end else begin
            state_d = EMPTY;
            oh_d    = '0;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        oh_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      oh_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_rr_issue_select.sv
// tb/tb_rr_issue_select.sv - directed bench for rr_issue_select
module tb_rr_issue_select;
  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic inv_en;
  logic hold_prev;
  logic [11:0] hold_snap;

  rr_issue_select_if #(.NUM_REQ(8)) bus ();

  rr_issue_select #(.NUM_REQ(8), .GATE_DELAY(50)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.req      = 8'h00;
    bus.outReady = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (inv_en) begin
      tests++;
      if (!$onehot0(bus.grantOneHot)) begin
        fails++;
        $display("FAIL inv_onehot0: grantOneHot=%b", bus.grantOneHot);
      end
      tests++;
      if (bus.grantValid !== (|bus.grantOneHot)) begin
        fails++;
        $display("FAIL inv_valid_or: grantValid=%b grantOneHot=%b", bus.grantValid, bus.grantOneHot);
      end
      if (bus.grantValid) begin
        tests++;
        if (bus.grantOneHot !== (8'b1 << bus.grantIdx)) begin
          fails++;
          $display("FAIL inv_idx_onehot: grantOneHot=%b grantIdx=%0d", bus.grantOneHot, bus.grantIdx);
        end
      end
      if (hold_prev) begin
        tests++;
        if ({bus.grantValid, bus.grantIdx, bus.grantOneHot} !== hold_snap) begin
          fails++;
          $display("FAIL inv_hold_stable: got %h required %h",
                   {bus.grantValid, bus.grantIdx, bus.grantOneHot}, hold_snap);
        end
      end
      hold_prev <= bus.grantValid && !bus.outReady && !reset;
      hold_snap <= {bus.grantValid, bus.grantIdx, bus.grantOneHot};
    end
  end

  task automatic test_reset();
    reset        = 1'b1;
    bus.req      = 8'hFF;
    bus.outReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      tests++;
      if (bus.grantValid !== 1'b0 || bus.grantOneHot !== 8'h00 || bus.grantIdx !== 3'd0 || bus.issueFire !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: got v=%b idx=%0d oh=%h fire=%b required 0,0,00,0",
                 bus.grantValid, bus.grantIdx, bus.grantOneHot, bus.issueFire);
      end
      inv_en = 1'b1;
    end
    reset = 1'b0;
    cyc();
    tests++;
    if (bus.grantValid !== 1'b1 || bus.grantIdx !== 3'd0) begin
      fails++;
      $display("FAIL reset_first_grant: got v=%b idx=%0d required 1,0", bus.grantValid, bus.grantIdx);
    end
  endtask

  task automatic test_basic_rr();
    logic [2:0] exp_idx [5] = '{3'd2, 3'd5, 3'd2, 3'd5, 3'd2};
    logic [2:0] exp_ptr [5] = '{3'd0, 3'd3, 3'd6, 3'd3, 3'd6};
    do_reset();
    bus.req      = 8'b0010_0100;
    bus.outReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      tests++;
      if (bus.grantValid !== 1'b1 || bus.grantIdx !== exp_idx[k]) begin
        fails++;
        $display("FAIL basic_rr_idx[%0d]: got v=%b idx=%0d required 1,%0d", k, bus.grantValid, bus.grantIdx, exp_idx[k]);
      end
      tests++;
      if (dut.ptr_q !== exp_ptr[k]) begin
        fails++;
        $display("FAIL basic_rr_ptr[%0d]: got %0d required %0d", k, dut.ptr_q, exp_ptr[k]);
      end
    end
  endtask

  task automatic test_full_load();
    logic [2:0] exp;
    do_reset();
    bus.req      = 8'hFF;
    bus.outReady = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cyc();
      exp = 3'(k);
      tests++;
      if (bus.grantValid !== 1'b1 || bus.grantIdx !== exp || bus.issueFire !== 1'b1) begin
        fails++;
        $display("FAIL full_load[%0d]: got v=%b idx=%0d fire=%b required 1,%0d,1",
                 k, bus.grantValid, bus.grantIdx, bus.issueFire, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] req_seq [4] = '{8'h08, 8'h81, 8'h00, 8'h00};
    do_reset();
    bus.req      = 8'h08;
    bus.outReady = 1'b0;
    cyc();
    tests++;
    if (bus.grantValid !== 1'b1 || bus.grantIdx !== 3'd3) begin
      fails++;
      $display("FAIL bp_initial: got v=%b idx=%0d required 1,3", bus.grantValid, bus.grantIdx);
    end
    for (int k = 0; k < 4; k++) begin
      bus.req = req_seq[k];
      cyc();
      tests++;
      if (bus.grantValid !== 1'b1 || bus.grantIdx !== 3'd3 || bus.grantOneHot !== 8'h08 || bus.issueFire !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b idx=%0d oh=%h fire=%b required 1,3,08,0",
                 k, bus.grantValid, bus.grantIdx, bus.grantOneHot, bus.issueFire);
      end
    end
    bus.req      = 8'h81;
    bus.outReady = 1'b1;
    #1;
    tests++;
    if (bus.issueFire !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_fire: got %b required 1", bus.issueFire);
    end
    cyc();
    tests++;
    if (bus.grantValid !== 1'b1 || bus.grantIdx !== 3'd7 || dut.ptr_q !== 3'd4) begin
      fails++;
      $display("FAIL bp_after: got v=%b idx=%0d ptr=%0d required 1,7,4", bus.grantValid, bus.grantIdx, dut.ptr_q);
    end
  endtask

  task automatic test_single_exclusion();
    logic exp_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    bus.req      = 8'h08;
    bus.outReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      tests++;
      if (bus.grantValid !== exp_v[k] || (exp_v[k] && bus.grantIdx !== 3'd3)) begin
        fails++;
        $display("FAIL single_excl[%0d]: got v=%b idx=%0d required %b,3", k, bus.grantValid, bus.grantIdx, exp_v[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req      = 8'h20;
    bus.outReady = 1'b1;
    cyc();
    cyc();
    tests++;
    if (bus.grantValid !== 1'b0 || dut.ptr_q !== 3'd6) begin
      fails++;
      $display("FAIL mid_prep: got v=%b ptr=%0d required 0,6", bus.grantValid, dut.ptr_q);
    end
    bus.outReady = 1'b0;
    cyc();
    tests++;
    if (bus.grantValid !== 1'b1 || bus.grantIdx !== 3'd5) begin
      fails++;
      $display("FAIL mid_held: got v=%b idx=%0d required 1,5", bus.grantValid, bus.grantIdx);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (bus.issueFire !== 1'b0) begin
      fails++;
      $display("FAIL mid_no_fire: got %b required 0", bus.issueFire);
    end
    cyc();
    tests++;
    if (bus.grantValid !== 1'b0 || bus.grantOneHot !== 8'h00 || dut.ptr_q !== 3'd0 || bus.issueFire !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got v=%b oh=%h ptr=%0d fire=%b required 0,00,0,0",
               bus.grantValid, bus.grantOneHot, dut.ptr_q, bus.issueFire);
    end
    reset   = 1'b0;
    bus.req = 8'h81;
    cyc();
    tests++;
    if (bus.grantValid !== 1'b1 || bus.grantIdx !== 3'd0) begin
      fails++;
      $display("FAIL mid_restart: got v=%b idx=%0d required 1,0", bus.grantValid, bus.grantIdx);
    end
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    inv_en       = 1'b0;
    hold_prev    = 1'b0;
    hold_snap    = '0;
    reset        = 1'b1;
    bus.req      = 8'hFF;
    bus.outReady = 1'b1;
    test_reset();
    test_basic_rr();
    test_full_load();
    test_backpressure();
    test_single_exclusion();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_issue_select.md
Name: rr_issue_select

Overview:
- Round-robin issue arbiter for an N-entry reservation-station bank.
- Picks one ready entry per cycle and registers the choice as a binary index, grantIdx.
- grantIdx drives the sel input of the bank's N:1 Mux tree, which steers the granted entry's operand/opcode bits to the execute stage.
- Also returns a one-hot grant so the reservation station can free the issued entry.

Parameters:
- NUM_REQ, 8, number of reservation-station entries. Must be a power of two and >= 2; any other value is an elaboration error. This is the same as the downstream Mux's MUX_WIDTH.
- GATE_DELAY, 50, delay applied to all instantiated primitive gates. Behavioural always_ff/always_comb logic carries no delay.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  bit i = entry i valid and operands ready.
- outReady  input  1  execute stage can accept an issue this cycle.
- grantValid  output  1  grantIdx/grantOneHot hold a valid pending issue.
- grantIdx  output  $clog2(NUM_REQ)  binary index of the granted entry; drives the Mux sel.
- grantOneHot  output  NUM_REQ  one-hot form of grantIdx; all zero when grantValid=0.
- issueFire  output  1  combinational grantValid && outReady; the entry is consumed this cycle.

Behaviour:
- State: output register {grantValid, grantIdx, grantOneHot}; round-robin pointer ptr, width $clog2(NUM_REQ).
- Reset (synchronous, active-high): grantValid=0, grantIdx=0, grantOneHot=0, ptr=0. issueFire follows as 0. Reset overrides all other activity in the same cycle.
- FSM:
  - EMPTY (grantValid=0) and HELD (grantValid=1).
  - EMPTY -> HELD when masked req != 0.
  - HELD -> HELD (reload) on issueFire with masked req != 0.
  - HELD -> EMPTY on issueFire with masked req == 0.
  - HELD with outReady=0 stays HELD; all outputs stay bit-stable.
- Slot free condition: slotFree = !grantValid || issueFire.
- Search:
  - Runs when slotFree is true.
  - Candidate set = req & ~excl.
  - excl = grantOneHot when issueFire=1, otherwise 0. The just-issued entry is never re-granted in the next cycle; the reservation station clears its req one cycle later.
  - Search base = (grantIdx+1) mod NUM_REQ when issueFire=1, otherwise ptr.
  - Scan base, base+1, ..., wrapping modulo NUM_REQ. The first asserted candidate wins.
  - The result is registered: req sampled in cycle t appears on grantIdx in cycle t+1. Latency is exactly 1 cycle; there is no combinational req->grantIdx path.
- Pointer:
  - On issueFire: ptr <= (grantIdx+1) mod NUM_REQ.
  - Otherwise ptr holds.
  - ptr never changes while in EMPTY.
- Request withdrawal while HELD (req[grantIdx] drops with outReady=0): the grant is NOT revoked. The reservation station must keep an entry valid until it has been issued.
- Throughput: one issue per cycle when outReady=1 and at least one eligible non-excluded request exists.
- Fairness: any continuously asserted req bit is granted within NUM_REQ issues.
- Widths: all index arithmetic is modulo NUM_REQ by natural $clog2 truncation. No overflow flags.
- Invariants (assert in bench):
  - $onehot0(grantOneHot).
  - grantValid == |grantOneHot.
  - grantOneHot == (1 << grantIdx) when valid.
  - grantValid outputs stable while grantValid && !outReady.

Test Plan:
- Reset: drive reset=1 for 2 cycles with req=8'hFF, outReady=1 -> grantValid=0, grantOneHot=0, grantIdx=0, issueFire=0 throughout; after release, first grant appears 1 cycle later with grantIdx=0.
- Basic round-robin: req=8'b0010_0100 held, outReady=1 -> grantIdx sequence 2,5,2,5,... with grantValid=1 every cycle and ptr alternating 3,6.
- Full load: req=8'hFF held, outReady=1 -> grantIdx 0,1,2,...,7,0 on consecutive cycles, issueFire=1 every cycle.
- Backpressure: HELD at grantIdx=3, outReady=0 for 4 cycles while req changes 8'h08->8'h81->8'h00 -> grantIdx=3 and grantOneHot=8'h08 unchanged. Then outReady=1 with req=8'h81 -> issueFire, next grantIdx=7.
- Single entry exclusion: req=8'h08 held, outReady=1 -> grantValid pattern 1,0,1,0 with grantIdx=3 whenever valid.
- Reset mid-operation: HELD at grantIdx=5, outReady=0, assert reset 1 cycle -> grantValid=0 and ptr=0 next cycle, with no issueFire. Then req=8'h81 -> grantIdx=0 (ptr restarted at 0).
